// File: rtl/apb_mst_pkg.sv
// Shared types and constants for the APB configuration master:
// FSM state encoding, response error codes and the default access timeout.
package apb_mst_pkg;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_VERIFY  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP,
    S_VSETUP,
    S_VACCESS
  } state_e;

endpackage

// File: rtl/apb_cfg_master_if.sv
// Bundle of the command/response handshake and APB bus signals of apb_cfg_master,
// for harnesses and integration; master modport is the apb_cfg_master side.
interface apb_cfg_master_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic [1:0]            rsp_err;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic                  pready;
  logic [31:0]           prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pready, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_cfg_master.sv
// Single-outstanding APB master turning command requests into APB transfers.
// Define APB_MST_VERIFY_EN to follow each successful write with a readback compare.
module apb_cfg_master
  import apb_mst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [31:0]           i_cmd_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_rdata,
  output logic [1:0]            o_rsp_err,
  output logic [ADDR_WIDTH-1:0] o_PADDR,
  output logic                  o_PSEL,
  output logic                  o_PENABLE,
  output logic                  o_PWRITE,
  output logic [31:0]           o_PWDATA,
  input  logic                  i_PREADY,
  input  logic [31:0]           i_PRDATA
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [1:0]            err_q, err_d;
  logic                  timeout;

  // cnt_q holds the number of already-elapsed ACCESS cycles; PREADY wins on the last one
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    o_cmd_ready = (state_q == S_IDLE) && !rst;
    o_PWRITE    = write_q && (state_q inside {S_SETUP, S_ACCESS});
`ifdef APB_MST_VERIFY_EN
    o_PSEL      = state_q inside {S_SETUP, S_ACCESS, S_VSETUP, S_VACCESS};
    o_PENABLE   = state_q inside {S_ACCESS, S_VACCESS};
`else
    o_PSEL      = state_q inside {S_SETUP, S_ACCESS};
    o_PENABLE   = state_q == S_ACCESS;
`endif
    o_PWDATA    = o_PWRITE ? wdata_q : '0;
    o_PADDR     = addr_q;
    o_rsp_valid = state_q == S_RESP;
    o_rsp_rdata = rdata_q;
    o_rsp_err   = err_q;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          addr_d  = i_cmd_addr;
          write_d = i_cmd_write;
          wdata_d = i_cmd_wdata;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (i_PREADY) begin
          err_d = ERR_OK;
`ifdef APB_MST_VERIFY_EN
          if (write_q) begin
            state_d = S_VSETUP;
          end else begin
            rdata_d = i_PRDATA;
            state_d = S_RESP;
          end
`else
          rdata_d = write_q ? wdata_q : i_PRDATA;
          state_d = S_RESP;
`endif
        end else if (timeout) begin
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`ifdef APB_MST_VERIFY_EN
      S_VSETUP: begin
        cnt_d   = '0;
        state_d = S_VACCESS;
      end
      S_VACCESS: begin
        if (i_PREADY) begin
          if (i_PRDATA == wdata_q) begin
            err_d   = ERR_OK;
            rdata_d = wdata_q;
          end else begin
            err_d   = ERR_VERIFY;
            rdata_d = i_PRDATA;
          end
          state_d = S_RESP;
        end else if (timeout) begin
          err_d   = ERR_TIMEOUT;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`endif
      S_RESP: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/apb_cfg_master.md
APB_CFG_MASTER -- requirements
Module: apb_cfg_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, APB address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS-phase wait cycles; 0 disables the timeout.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk, rst.
REQ-004 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  command accepted this cycle
- i_cmd_write  in  1  1=write, 0=read
- i_cmd_addr  in  ADDR_WIDTH  target address
- i_cmd_wdata  in  32  write data
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  response consumed
- o_rsp_rdata  out  32  read data (write data echo for writes)
- o_rsp_err  out  2  00 ok, 01 timeout, 10 verify mismatch
- o_PADDR  out  ADDR_WIDTH  APB address
- o_PSEL  out  1  APB select
- o_PENABLE  out  1  APB enable
- o_PWRITE  out  1  APB direction
- o_PWDATA  out  32  APB write data
- i_PREADY  in  1  completer ready
- i_PRDATA  in  32  completer read data

Function
REQ-005 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE, plus VSETUP/VACCESS under REQ-017.
REQ-006 SHALL assert o_cmd_ready only in IDLE; a command is accepted on i_cmd_valid && o_cmd_ready, and its fields are latched.
REQ-007 SHALL spend exactly one cycle in SETUP: PSEL=1, PENABLE=0, with PADDR/PWRITE/PWDATA taken from the latched command.
REQ-008 SHALL, in ACCESS, drive PSEL=1 and PENABLE=1 and hold PADDR/PWRITE/PWDATA stable until the PREADY cycle.
REQ-009 SHALL drive PWDATA=0 for reads.
REQ-010 SHALL, on PREADY in ACCESS, capture PRDATA for reads or the latched wdata for writes, set err=00, and go to RESP; PSEL/PENABLE fall on the next edge.
REQ-011 SHALL count ACCESS cycles; if TIMEOUT_CYCLES>0 and the count reaches TIMEOUT_CYCLES without PREADY, drop PSEL/PENABLE, set err=01, rdata=0, and go to RESP.
REQ-012 SHALL hold o_rsp_valid and its payload stable in RESP until i_rsp_ready, then return to IDLE; a new command is accepted no earlier than the following cycle.
REQ-013 SHALL meet this minimum latency: command accepted at cycle N, SETUP at N+1, ACCESS at N+2, o_rsp_valid at N+3 when PREADY=1 at N+2.
REQ-014 SHALL ignore i_PREADY/i_PRDATA outside ACCESS/VACCESS.

Reset
REQ-015 SHALL, while rst=1 at a clock edge, enter IDLE and drive o_PSEL, o_PENABLE, o_PWRITE, o_rsp_valid=0, o_PADDR, o_PWDATA, o_rsp_rdata=0, o_rsp_err=00; o_cmd_ready=0 during reset and 1 the cycle after release.
REQ-016 SHALL, on reset mid-transfer, abort the APB transfer and discard any pending response without emitting it.

Configuration
REQ-017 SHALL, with APB_MST_VERIFY_EN defined, follow each successful write with a read to the same address (VSETUP, VACCESS, same timing and timeout rules); a mismatch gives err=10 with the read value in rdata, a VACCESS timeout gives err=01, a match gives err=00 with the echo.
REQ-018 SHALL, without APB_MST_VERIFY_EN, exclude VSETUP/VACCESS logic entirely; writes respond immediately after ACCESS.

Structure
REQ-019 SHALL place the state enumeration, error code constants (ERR_OK, ERR_TIMEOUT, ERR_VERIFY) and the default TIMEOUT_CYCLES in package apb_mst_pkg.
REQ-020 SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-021 Write 0x0000_0155 to addr 0x004, completer PREADY=1 immediately -> SETUP 1 cycle, ACCESS 1 cycle, o_rsp_valid at N+3, err=00, rdata=0x155.
REQ-022 Read addr 0x010, PREADY delayed 3 ACCESS cycles, PRDATA=0x0000_00AB -> PADDR/PSEL stable for all 3 cycles, rdata=0xAB, err=00.
REQ-023 TIMEOUT_CYCLES=16, PREADY held 0 -> PSEL drops after 16 ACCESS cycles, err=01, rdata=0.
REQ-024 i_rsp_ready held 0 for 5 cycles with i_cmd_valid=1 -> response stable, o_cmd_ready=0 throughout, next command accepted one cycle after the response handshake.
REQ-025 rst=1 asserted during ACCESS -> PSEL/PENABLE=0 at the next edge, no o_rsp_valid emitted, o_cmd_ready=1 the cycle after release.
REQ-026 APB_MST_VERIFY_EN defined, write 0x3FF with the completer returning 0x0FF on readback -> verify read issued to the same address, err=10, rdata=0x0FF.
